// File: rtl/dreq_credits_wr_mc.sv
// rtl/dreq_credits_wr_mc.sv - per-channel data-credit gate merging write requests by round-robin
module dreq_credits_wr_mc #(
    parameter int N_CHAN    = 4,
    parameter int DATA_BITS = 512,
    parameter int LEN_BITS  = 28,
    parameter int REQ_BITS  = 128,
    parameter int CRED_MAX  = 64,
    parameter int CNT_BITS  = $clog2(CRED_MAX + 1),
    localparam int ID_BITS  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [N_CHAN-1:0]            s_req_valid,
    output logic [N_CHAN-1:0]            s_req_ready,
    input  logic [N_CHAN*LEN_BITS-1:0]   s_req_len,
    input  logic [N_CHAN*REQ_BITS-1:0]   s_req_data,
    input  logic [N_CHAN-1:0]            xfer,
    output logic                         m_req_valid,
    input  logic                         m_req_ready,
    output logic [REQ_BITS-1:0]          m_req_data,
    output logic [ID_BITS-1:0]           m_req_id,
    output logic [N_CHAN*CNT_BITS-1:0]   cnt_out,
    output logic [N_CHAN-1:0]            err_ovf,
    output logic [N_CHAN-1:0]            err_oversize
);

    localparam int BEAT_BYTES = DATA_BITS / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int NB_BITS    = LEN_BITS + 1;

    localparam logic [NB_BITS-1:0]  ROUND_ADD   = NB_BITS'(BEAT_BYTES - 1);
    localparam logic [NB_BITS-1:0]  CRED_MAX_NB = NB_BITS'(CRED_MAX);
    localparam logic [CNT_BITS:0]   CRED_MAX_C  = (CNT_BITS + 1)'(CRED_MAX);

    logic [CNT_BITS-1:0] cnt     [N_CHAN];
    logic [CNT_BITS:0]   cnt_sum [N_CHAN];
    logic [NB_BITS-1:0]  n_beats [N_CHAN];
    logic [ID_BITS-1:0]  rr;
    logic [N_CHAN-1:0]   elig;
    logic [N_CHAN-1:0]   grant;
    logic                grant_any;
    logic [ID_BITS-1:0]  grant_id;
    logic [REQ_BITS-1:0] grant_data;
    logic                can_load;

    // Channel index base+off, wrapped modulo N_CHAN (off < N_CHAN).
    function automatic logic [ID_BITS-1:0] rr_add(input logic [ID_BITS-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_CHAN) begin
            sum = sum - N_CHAN;
        end
        return ID_BITS'(sum);
    endfunction

    assign can_load    = !m_req_valid || m_req_ready;
    assign s_req_ready = grant;

    // Beats needed per head request, eligibility, and the credit balance after this cycle.
    always_comb begin
        for (int i = 0; i < N_CHAN; i++) begin
            n_beats[i] = ({1'b0, s_req_len[i*LEN_BITS +: LEN_BITS]} + ROUND_ADD) >> BEAT_SHIFT;
            elig[i]    = s_req_valid[i]
                         && (NB_BITS'(cnt[i]) >= n_beats[i])
                         && (n_beats[i] <= CRED_MAX_NB);
            // A grant implies n_beats <= cnt, so the debit fits the counter width and never underflows.
            cnt_sum[i] = {1'b0, cnt[i]} + (CNT_BITS + 1)'(xfer[i])
                         - (grant[i] ? n_beats[i][CNT_BITS:0] : '0);
        end
    end

    // Round-robin search from rr for the first eligible channel when the output slot is free.
    always_comb begin
        grant      = '0;
        grant_any  = 1'b0;
        grant_id   = '0;
        grant_data = '0;
        if (!areset && can_load) begin
            for (int k = 0; k < N_CHAN; k++) begin
                if (!grant_any && elig[rr_add(rr, k)]) begin
                    grant_any = 1'b1;
                    grant_id  = rr_add(rr, k);
                end
            end
        end
        for (int i = 0; i < N_CHAN; i++) begin
            if (grant_any && (grant_id == ID_BITS'(i))) begin
                grant[i]   = 1'b1;
                grant_data = s_req_data[i*REQ_BITS +: REQ_BITS];
            end
        end
    end

    // Credit counters with saturation at the ceiling, plus sticky error flags.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < N_CHAN; i++) begin
                cnt[i] <= '0;
            end
            err_ovf      <= '0;
            err_oversize <= '0;
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (cnt_sum[i] > CRED_MAX_C) begin
                    cnt[i]     <= CNT_BITS'(CRED_MAX);
                    err_ovf[i] <= 1'b1;
                end else begin
                    cnt[i] <= cnt_sum[i][CNT_BITS-1:0];
                end
                if (s_req_valid[i] && (n_beats[i] > CRED_MAX_NB)) begin
                    err_oversize[i] <= 1'b1;
                end
            end
        end
    end

    // Priority pointer moves just past the most recent winner.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rr <= '0;
        end else if (grant_any) begin
            rr <= rr_add(grant_id, 1);
        end
    end

    // Single output slot: reloads on a grant even in the cycle the held entry is consumed.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_req_valid <= 1'b0;
            m_req_data  <= '0;
            m_req_id    <= '0;
        end else if (grant_any) begin
            m_req_valid <= 1'b1;
            m_req_data  <= grant_data;
            m_req_id    <= grant_id;
        end else if (m_req_ready) begin
            m_req_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_CHAN; i++) begin : g_cnt_out
        assign cnt_out[i*CNT_BITS +: CNT_BITS] = cnt[i];
    end

endmodule

// File: tb/tb_dreq_credits_wr_mc.sv
// tb/tb_dreq_credits_wr_mc.sv - randomized and directed checks of dreq_credits_wr_mc against a reference model
module tb_dreq_credits_wr_mc;

    logic         aclk = 1'b0;
    logic         areset;
    logic [3:0]   s_req_valid;
    logic [3:0]   s_req_ready;
    logic [111:0] s_req_len;
    logic [511:0] s_req_data;
    logic [3:0]   xfer;
    logic         m_req_valid;
    logic         m_req_ready;
    logic [127:0] m_req_data;
    logic [1:0]   m_req_id;
    logic [27:0]  cnt_out;
    logic [3:0]   err_ovf;
    logic [3:0]   err_oversize;

    dreq_credits_wr_mc dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req_len    (s_req_len),
        .s_req_data   (s_req_data),
        .xfer         (xfer),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req_data   (m_req_data),
        .m_req_id     (m_req_id),
        .cnt_out      (cnt_out),
        .err_ovf      (err_ovf),
        .err_oversize (err_oversize)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int           mcnt [4];
    int           mrr;
    bit           mv;
    logic [127:0] mdata;
    int           mid;
    logic [3:0]   movf;
    logic [3:0]   moversz;

    logic [3:0]   obs_ready;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int nb(input int ch);
        int unsigned len;
        len = s_req_len[ch*28 +: 28];
        return int'((len + 63) / 64);
    endfunction

    function automatic logic [6:0] get_cnt(input int ch);
        return cnt_out[ch*7 +: 7];
    endfunction

    task automatic set_len(input int ch, input int unsigned len);
        s_req_len[ch*28 +: 28] = len[27:0];
    endtask

    task automatic set_data(input int ch);
        s_req_data[ch*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // One clock: predict grant, check ready, advance model at the edge, check registered outputs.
    task automatic cycle();
        int  g;
        int  c;
        int  v;
        bit  can;
        can = !mv || m_req_ready;
        g = -1;
        if (!areset && can) begin
            for (int k = 0; k < 4; k++) begin
                c = (mrr + k) % 4;
                if (g < 0 && s_req_valid[c] && nb(c) <= 64 && mcnt[c] >= nb(c)) g = c;
            end
        end
        #1;
        obs_ready = s_req_ready;
        chk("s_req_ready", obs_ready, (g >= 0) ? (128'(1) << g) : 128'(0));
        @(posedge aclk);
        if (areset) begin
            for (int i = 0; i < 4; i++) mcnt[i] = 0;
            mrr = 0; mv = 0; mdata = '0; mid = 0; movf = '0; moversz = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                v = mcnt[i] + int'(xfer[i]) - ((g == i) ? nb(i) : 0);
                if (v > 64) begin
                    v = 64;
                    movf[i] = 1'b1;
                end
                mcnt[i] = v;
                if (s_req_valid[i] && nb(i) > 64) moversz[i] = 1'b1;
            end
            if (g >= 0) begin
                mv = 1; mdata = s_req_data[g*128 +: 128]; mid = g; mrr = (g + 1) % 4;
            end else if (m_req_ready) begin
                mv = 0;
            end
        end
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("cnt%0d", i), get_cnt(i), mcnt[i]);
        chk("m_req_valid", m_req_valid, mv);
        if (mv) begin
            chk("m_req_data", m_req_data, mdata);
            chk("m_req_id", m_req_id, mid);
        end
        chk("err_ovf", err_ovf, movf);
        chk("err_oversize", err_oversize, moversz);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        s_req_valid = '0;
        xfer = '0;
        cycle();
        areset = 1'b0;
    endtask

    task automatic pick_len(input int ch);
        int r;
        r = $urandom_range(0, 63);
        if (r == 0)      set_len(ch, 0);
        else if (r == 1) set_len(ch, $urandom_range(4161, 20000));
        else if (r == 2) set_len(ch, 4096);
        else             set_len(ch, $urandom_range(1, 1024));
    endtask

    initial begin
        logic [127:0] first;
        int           grants;

        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        mrr = 0; mv = 0; mdata = '0; mid = 0; movf = '0; moversz = '0;
        areset = 1'b1; s_req_valid = '0; s_req_len = '0; s_req_data = '0;
        xfer = '0; m_req_ready = 1'b1; obs_ready = '0;
        repeat (2) cycle();
        areset = 1'b0;
        chk("rst_m_valid", m_req_valid, 0);
        chk("rst_cnt", cnt_out, 0);
        chk("rst_err", {err_ovf, err_oversize}, 0);

        // basic release
        s_req_valid = 4'b0001; set_len(0, 256); set_data(0);
        xfer = 4'b0001;
        repeat (3) begin
            cycle();
            chk("basic_wait", obs_ready, 0);
        end
        cycle();
        xfer = 4'b0000;
        cycle();
        chk("basic_ready", obs_ready, 4'b0001);
        chk("basic_m_valid", m_req_valid, 1);
        chk("basic_id", m_req_id, 0);
        chk("basic_cnt", get_cnt(0), 0);
        s_req_valid = 4'b0000;
        cycle();

        // ceiling rounding
        do_reset();
        xfer = 4'b0100; cycle();
        xfer = 4'b0000; s_req_valid = 4'b0100; set_len(2, 100); set_data(2);
        cycle();
        chk("ceil_wait", obs_ready, 0);
        xfer = 4'b0100; cycle();
        xfer = 4'b0000; cycle();
        chk("ceil_grant", obs_ready, 4'b0100);
        chk("ceil_cnt", get_cnt(2), 0);
        s_req_valid = 4'b0000;
        cycle();

        // round-robin
        do_reset();
        xfer = 4'b1111; repeat (4) cycle();
        xfer = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            set_len(i, 64); set_data(i);
        end
        s_req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rr_id", m_req_id, i % 4);
        end
        for (int i = 0; i < 4; i++) chk("rr_cnt", get_cnt(i), 2);
        s_req_valid = 4'b0000;
        cycle();

        // simultaneous grant and xfer
        do_reset();
        xfer = 4'b0010; repeat (4) cycle();
        s_req_valid = 4'b0010; set_len(1, 256); set_data(1);
        cycle();
        chk("simul_ready", obs_ready, 4'b0010);
        chk("simul_cnt", get_cnt(1), 1);
        s_req_valid = 4'b0000; xfer = 4'b0000;
        cycle();

        // backpressure
        do_reset();
        xfer = 4'b0011; repeat (2) cycle();
        set_len(0, 64); set_len(1, 64); set_data(0); set_data(1);
        s_req_valid = 4'b0011; m_req_ready = 1'b0;
        grants = 0; first = '0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (obs_ready != 0) grants++;
            if (i == 0) first = m_req_data;
            else chk("bp_data_stable", m_req_data, first);
        end
        chk("bp_one_grant", grants, 1);
        chk("bp_first_data", first, s_req_data[127:0]);
        chk("bp_cnt0", get_cnt(0), 11);
        chk("bp_cnt1", get_cnt(1), 12);
        xfer = 4'b0000; m_req_ready = 1'b1;
        cycle();
        chk("bp_second_grant", obs_ready, 4'b0010);
        chk("bp_second_id", m_req_id, 1);
        s_req_valid = 4'b0000;
        cycle();

        // errors and reset
        do_reset();
        xfer = 4'b1000; repeat (70) cycle();
        xfer = 4'b0000;
        chk("ovf_cnt3", get_cnt(3), 64);
        chk("ovf_flag3", err_ovf[3], 1);
        s_req_valid = 4'b0100; set_len(2, 4224);
        xfer = 4'b0100; repeat (3) cycle();
        xfer = 4'b0000; repeat (3) cycle();
        chk("oversize_flag2", err_oversize[2], 1);
        chk("oversize_no_grant", obs_ready, 0);
        s_req_valid = 4'b0000;
        areset = 1'b1; cycle(); areset = 1'b0;
        chk("rst2_cnt", cnt_out, 0);
        chk("rst2_flags", {err_ovf, err_oversize}, 0);
        chk("rst2_m_valid", m_req_valid, 0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            areset = ($urandom_range(0, 149) == 0);
            for (int ch = 0; ch < 4; ch++) begin
                if (s_req_valid[ch] && obs_ready[ch]) s_req_valid[ch] = 1'b0;
                if (!s_req_valid[ch] && $urandom_range(0, 1) == 1) begin
                    s_req_valid[ch] = 1'b1;
                    pick_len(ch);
                    set_data(ch);
                end
            end
            xfer = 4'($urandom());
            m_req_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
